// File: rtl/tile_map_writer_pkg.sv
// Shared tile codes, playfield geometry and FSM state type for the tile map
// writer and the tank collision logic.
package tile_pkg;

    localparam logic [1:0] TILE_EMPTY   = 2'd0;
    localparam logic [1:0] TILE_BRICK   = 2'd1;
    localparam logic [1:0] TILE_STEEL   = 2'd2;
    localparam logic [1:0] TILE_DAMAGED = 2'd3;

    localparam int MAP_W      = 20;
    localparam int MAP_H      = 15;
    localparam int MAP_CELLS  = MAP_W * MAP_H;
    localparam int TILE_SHIFT = 5;

    typedef enum logic {
        ST_LOAD,
        ST_RUN
    } tile_state_t;

endpackage

// File: rtl/tile_map_writer_if.sv
// Shell-impact request channel: the shell logic drives a pixel coordinate,
// the tile map writer answers with hit_ready.
interface tile_map_writer_if;

    logic       hit_valid;
    logic [9:0] hit_x;
    logic [9:0] hit_y;
    logic       hit_ready;

    modport master (
        output hit_valid,
        output hit_x,
        output hit_y,
        input  hit_ready
    );

    modport slave (
        input  hit_valid,
        input  hit_x,
        input  hit_y,
        output hit_ready
    );

endinterface

// File: rtl/tile_map_writer_tile_index.sv
// Pixel coordinate to playfield cell index, with an in_range flag for
// coordinates beyond the right or bottom edge. Purely combinational.
module tile_index #(
    parameter int MAP_W      = tile_pkg::MAP_W,
    parameter int MAP_H      = tile_pkg::MAP_H,
    parameter int TILE_SHIFT = tile_pkg::TILE_SHIFT
) (
    input  logic [9:0] x,
    input  logic [9:0] y,
    output logic [8:0] idx,
    output logic       in_range
);

    logic [9:0] row;
    logic [9:0] col;

    // Out-of-range coordinates report index 0 so callers never see a wrapped cell.
    always_comb begin
        row      = y >> TILE_SHIFT;
        col      = x >> TILE_SHIFT;
        in_range = (int'(row) < MAP_H) && (int'(col) < MAP_W);
        idx      = in_range ? 9'(int'(row) * MAP_W + int'(col)) : 9'd0;
    end

endmodule

// File: rtl/tile_map_writer.sv
// Playfield tile map: loads a level from ROM, then applies shell hits to bricks.
// Define TILE_MAP_DAMAGE_EN for two-hit bricks (1 -> 3 -> 0); otherwise bricks break in one hit.
module tile_map_writer #(
    parameter int MAP_W      = 20,
    parameter int MAP_H      = 15,
    parameter int TILE_SHIFT = 5
) (
    input  logic              frame_clk,
    input  logic              Reset,
    input  logic              level_load,
    input  logic [1:0]        level_sel,
    output logic [10:0]       rom_addr,
    input  logic [1:0]        rom_data,
    tile_map_writer_if.slave  hit,
    output logic [1:0]        map [MAP_W*MAP_H],
    output logic              load_done,
    output logic [8:0]        walls_left,
    output logic              level_clear
);

    import tile_pkg::*;

    localparam int CELLS = MAP_W * MAP_H;

    tile_state_t state;
    logic [8:0]  cnt;
    logic [1:0]  level;
    logic        hit_ready_r;
    logic        upd_pending;
    logic [8:0]  upd_idx;
    logic        upd_in_range;

    logic [8:0]  hit_idx;
    logic        hit_in_range;
    logic [8:0]  addr_cnt;
    logic [1:0]  load_code;
    logic [1:0]  hit_code;
    logic [1:0]  hit_new;

    assign hit.hit_ready = hit_ready_r;

    tile_index #(
        .MAP_W      (MAP_W),
        .MAP_H      (MAP_H),
        .TILE_SHIFT (TILE_SHIFT)
    ) u_tile_index (
        .x        (hit.hit_x),
        .y        (hit.hit_y),
        .idx      (hit_idx),
        .in_range (hit_in_range)
    );

    // On the final write cycle cnt sits one past the last cell; hold the address in range.
    always_comb begin
        addr_cnt = (cnt == 9'(CELLS)) ? 9'(CELLS - 1) : cnt;
        rom_addr = 11'(int'(level) * CELLS + int'(addr_cnt));
    end

    always_comb begin
        load_code = rom_data;
`ifndef TILE_MAP_DAMAGE_EN
        if (rom_data == TILE_DAMAGED)
            load_code = TILE_BRICK;
`endif
    end

    always_comb begin
        hit_code = map[upd_idx];
        hit_new  = hit_code;
        case (hit_code)
`ifdef TILE_MAP_DAMAGE_EN
            TILE_BRICK:   hit_new = TILE_DAMAGED;
`else
            TILE_BRICK:   hit_new = TILE_EMPTY;
`endif
            TILE_DAMAGED: hit_new = TILE_EMPTY;
            default:      hit_new = hit_code;
        endcase
    end

    // level_load outranks everything, so a hit waiting in its update cycle is simply dropped.
    always_ff @(posedge frame_clk or posedge Reset) begin
        if (Reset) begin
            state        <= ST_LOAD;
            cnt          <= 9'd0;
            level        <= 2'd0;
            walls_left   <= 9'd0;
            load_done    <= 1'b0;
            hit_ready_r  <= 1'b0;
            level_clear  <= 1'b0;
            upd_pending  <= 1'b0;
            upd_idx      <= 9'd0;
            upd_in_range <= 1'b0;
            for (int i = 0; i < CELLS; i++)
                map[i] <= TILE_EMPTY;
        end else begin
            level_clear <= 1'b0;
            if (level_load) begin
                state       <= ST_LOAD;
                cnt         <= 9'd0;
                level       <= level_sel;
                walls_left  <= 9'd0;
                load_done   <= 1'b0;
                hit_ready_r <= 1'b0;
                upd_pending <= 1'b0;
            end else begin
                case (state)
                    ST_LOAD: begin
                        if (cnt != 9'd0) begin
                            map[cnt - 9'd1] <= load_code;
                            if (load_code == TILE_BRICK || load_code == TILE_DAMAGED)
                                walls_left <= walls_left + 9'd1;
                        end
                        if (cnt == 9'(CELLS)) begin
                            state       <= ST_RUN;
                            load_done   <= 1'b1;
                            hit_ready_r <= 1'b1;
                        end else begin
                            cnt <= cnt + 9'd1;
                        end
                    end
                    ST_RUN: begin
                        if (upd_pending) begin
                            upd_pending <= 1'b0;
                            hit_ready_r <= 1'b1;
                            if (upd_in_range && hit_new != hit_code) begin
                                map[upd_idx] <= hit_new;
                                if (hit_new == TILE_EMPTY) begin
                                    assert (walls_left != 9'd0);
                                    walls_left <= walls_left - 9'd1;
                                    if (walls_left == 9'd1)
                                        level_clear <= 1'b1;
                                end
                            end
                        end else if (hit.hit_valid && hit_ready_r) begin
                            upd_pending  <= 1'b1;
                            hit_ready_r  <= 1'b0;
                            upd_idx      <= hit_idx;
                            upd_in_range <= hit_in_range;
                        end
                    end
                    default: state <= ST_LOAD;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_tile_map_writer.sv
// Bench for tile_map_writer: ROM model, fixed hit table on a patterned level,
// corner-case sequences and random hits against a tile-rule reference model.
module tb_tile_map_writer;

`ifdef TILE_MAP_DAMAGE_EN
    localparam bit DAMAGE_EN    = 1'b1;
    localparam int BRICK_HIT    = 3;
    localparam int BRICK_DELTA  = 0;
    localparam int SECOND_DELTA = -1;
    localparam int DMG_STORED   = 3;
`else
    localparam bit DAMAGE_EN    = 1'b0;
    localparam int BRICK_HIT    = 0;
    localparam int BRICK_DELTA  = -1;
    localparam int SECOND_DELTA = 0;
    localparam int DMG_STORED   = 1;
`endif

    logic        frame_clk = 1'b0;
    logic        Reset;
    logic        level_load;
    logic [1:0]  level_sel;
    logic [10:0] rom_addr;
    logic [1:0]  rom_data;
    logic [1:0]  map [300];
    logic        load_done;
    logic [8:0]  walls_left;
    logic        level_clear;

    tile_map_writer_if hit_bus ();

    tile_map_writer dut (
        .frame_clk   (frame_clk),
        .Reset       (Reset),
        .level_load  (level_load),
        .level_sel   (level_sel),
        .rom_addr    (rom_addr),
        .rom_data    (rom_data),
        .hit         (hit_bus),
        .map         (map),
        .load_done   (load_done),
        .walls_left  (walls_left),
        .level_clear (level_clear)
    );

    always #5 frame_clk = ~frame_clk;

    logic [1:0] rom [1200];
    always @(posedge frame_clk)
        rom_data <= (int'(rom_addr) < 1200) ? rom[rom_addr] : 2'd0;

    int clear_count = 0;
    always @(negedge frame_clk)
        if (level_clear) clear_count++;

    int checks   = 0;
    int failures = 0;
    int ref_map [300];
    int ref_walls;

    typedef struct {
        int x;
        int y;
        int idx;
        int exp_code;
        int delta;
    } vec_t;

    vec_t vecs [12];

    task automatic check_output(input string name, input int actual, input int expected);
        checks++;
        if (actual != expected) begin
            failures++;
            $display("[TB] FAIL %s actual=%0d expected=%0d", name, actual, expected);
        end
    endtask

    task automatic apply_stimulus(input int x, input int y);
        hit_bus.hit_valid = 1'b1;
        hit_bus.hit_x     = 10'(x);
        hit_bus.hit_y     = 10'(y);
        @(posedge frame_clk); #1;
        hit_bus.hit_valid = 1'b0;
        @(posedge frame_clk); #1;
    endtask

    task automatic fill_model(input int sel);
        int code;
        ref_walls = 0;
        for (int c = 0; c < 300; c++) begin
            code = int'(rom[sel*300 + c]);
            if (code == 3 && !DAMAGE_EN) code = 1;
            ref_map[c] = code;
            if (code == 1 || code == 3) ref_walls++;
        end
    endtask

    task automatic model_hit(input int x, input int y, output int idx);
        int r;
        int c;
        r   = y / 32;
        c   = x / 32;
        idx = -1;
        if (r < 15 && c < 20) begin
            idx = r*20 + c;
            if (ref_map[idx] == 1) begin
                ref_map[idx] = DAMAGE_EN ? 3 : 0;
                if (!DAMAGE_EN) ref_walls--;
            end else if (ref_map[idx] == 3) begin
                ref_map[idx] = 0;
                ref_walls--;
            end
        end
    endtask

    task automatic wait_load(inout int edges);
        while (!load_done && edges < 400) begin
            @(posedge frame_clk); #1;
            edges++;
        end
    endtask

    task automatic load_level(input int sel, output int edges);
        level_load = 1'b1;
        level_sel  = 2'(sel);
        @(posedge frame_clk); #1;
        level_load = 1'b0;
        edges = 0;
        wait_load(edges);
        fill_model(sel);
    endtask

    initial begin
        int edges;
        int idx;
        int walls_exp;
        int leaks;
        int nonzero;
        int rx;
        int ry;

        for (int c = 0; c < 300; c++) begin
            rom[c]       = 2'd1;
            rom[300 + c] = 2'd0;
            rom[600 + c] = 2'(c % 4);
            rom[900 + c] = 2'($urandom_range(0, 3));
        end
        rom[341] = 2'd1;

        vecs[0]  = '{650, 10,  19,  DMG_STORED, 0};
        vecs[1]  = '{70,  5,   2,   2,          0};
        vecs[2]  = '{3,   3,   0,   0,          0};
        vecs[3]  = '{40,  20,  1,   BRICK_HIT,  BRICK_DELTA};
        vecs[4]  = '{100, 0,   3,   0,          -1};
        vecs[5]  = '{10,  480, 299, DMG_STORED, 0};
        vecs[6]  = '{639, 479, 299, 0,          -1};
        vecs[7]  = '{40,  20,  1,   0,          SECOND_DELTA};
        vecs[8]  = '{680, 500, 0,   0,          0};
        vecs[9]  = '{320, 64,  50,  2,          0};
        vecs[10] = '{352, 96,  71,  0,          -1};
        vecs[11] = '{160, 224, 145, BRICK_HIT,  BRICK_DELTA};

        Reset             = 1'b1;
        level_load        = 1'b0;
        level_sel         = 2'd0;
        hit_bus.hit_valid = 1'b0;
        hit_bus.hit_x     = 10'd0;
        hit_bus.hit_y     = 10'd0;

        #12;
        check_output("reset_load_done", int'(load_done), 0);
        check_output("reset_hit_ready", int'(hit_bus.hit_ready), 0);
        check_output("reset_level_clear", int'(level_clear), 0);
        check_output("reset_rom_addr", int'(rom_addr), 0);
        check_output("reset_walls", int'(walls_left), 0);
        check_output("reset_map0", int'(map[0]), 0);

        @(posedge frame_clk); #1;
        Reset = 1'b0;
        edges = 0;
        wait_load(edges);
        fill_model(0);
        check_output("load0_edges", edges, 301);
        check_output("load0_walls", int'(walls_left), 300);
        check_output("load0_map0", int'(map[0]), 1);
        check_output("load0_map299", int'(map[299]), 1);
        check_output("load0_hit_ready", int'(hit_bus.hit_ready), 1);

        // Hit at (40,70): row 2, col 1, cell 41.
        hit_bus.hit_valid = 1'b1;
        hit_bus.hit_x     = 10'd40;
        hit_bus.hit_y     = 10'd70;
        @(posedge frame_clk); #1;
        hit_bus.hit_valid = 1'b0;
        check_output("ready_low_after_accept", int'(hit_bus.hit_ready), 0);
        check_output("map41_before_update", int'(map[41]), 1);
        @(posedge frame_clk); #1;
        check_output("map41_first_hit", int'(map[41]), BRICK_HIT);
        check_output("ready_back_high", int'(hit_bus.hit_ready), 1);
        check_output("walls_first_hit", int'(walls_left), 300 + BRICK_DELTA);
        apply_stimulus(40, 70);
        check_output("map41_second_hit", int'(map[41]), 0);
        check_output("walls_second_hit", int'(walls_left), 299);

        // Single-brick level at cell 41.
        load_level(1, edges);
        check_output("load1_walls", int'(walls_left), 1);
        rx = clear_count;
        apply_stimulus(40, 70);
        check_output("single_walls_after_first", int'(walls_left), DAMAGE_EN ? 1 : 0);
        apply_stimulus(40, 70);
        repeat (3) @(posedge frame_clk);
        #1;
        check_output("single_walls_final", int'(walls_left), 0);
        check_output("level_clear_pulses", clear_count - rx, 1);

        // Reload requested in the update cycle of a pending hit on cell 63.
        load_level(0, edges);
        hit_bus.hit_valid = 1'b1;
        hit_bus.hit_x     = 10'd100;
        hit_bus.hit_y     = 10'd100;
        @(posedge frame_clk); #1;
        hit_bus.hit_valid = 1'b0;
        level_load        = 1'b1;
        level_sel         = 2'd2;
        @(posedge frame_clk); #1;
        level_load = 1'b0;
        check_output("reload_rom_addr_start", int'(rom_addr), 600);
        check_output("reload_hit_ready", int'(hit_bus.hit_ready), 0);
        check_output("reload_load_done", int'(load_done), 0);
        check_output("reload_hit_discarded", int'(map[63]), 1);
        check_output("reload_walls_cleared", int'(walls_left), 0);
        @(posedge frame_clk); #1;
        check_output("reload_rom_addr_next", int'(rom_addr), 601);
        edges = 1;
        leaks = 0;
        while (!load_done && edges < 400) begin
            if (hit_bus.hit_ready) leaks++;
            @(posedge frame_clk); #1;
            edges++;
        end
        fill_model(2);
        check_output("reload_edges", edges, 301);
        check_output("reload_ready_leaks", leaks, 0);
        check_output("reload_walls", int'(walls_left), 150);
        check_output("reload_map63", int'(map[63]), ref_map[63]);

        walls_exp = 150;
        for (int i = 0; i < 12; i++) begin
            apply_stimulus(vecs[i].x, vecs[i].y);
            walls_exp += vecs[i].delta;
            check_output($sformatf("vec%0d_map%0d", i, vecs[i].idx), int'(map[vecs[i].idx]), vecs[i].exp_code);
            check_output($sformatf("vec%0d_walls", i), int'(walls_left), walls_exp);
        end

        // Reset asserted with cnt at 150.
        level_load = 1'b1;
        level_sel  = 2'd3;
        @(posedge frame_clk); #1;
        level_load = 1'b0;
        repeat (150) @(posedge frame_clk);
        #1;
        check_output("midload_rom_addr", int'(rom_addr), 900 + 150);
        Reset = 1'b1;
        #1;
        nonzero = 0;
        for (int c = 0; c < 300; c++)
            if (map[c] != 2'd0) nonzero++;
        check_output("midreset_map_nonzero", nonzero, 0);
        check_output("midreset_rom_addr", int'(rom_addr), 0);
        check_output("midreset_walls", int'(walls_left), 0);
        check_output("midreset_load_done", int'(load_done), 0);
        check_output("midreset_hit_ready", int'(hit_bus.hit_ready), 0);
        @(posedge frame_clk); #1;
        Reset = 1'b0;
        @(posedge frame_clk); #1;
        check_output("restart_rom_addr", int'(rom_addr), 1);
        edges = 1;
        wait_load(edges);
        check_output("restart_edges", edges, 301);
        check_output("restart_walls", int'(walls_left), 300);

        // Random hits on a random level against the reference model.
        load_level(3, edges);
        check_output("load3_walls", int'(walls_left), ref_walls);
        for (int n = 0; n < 60; n++) begin
            rx = int'($urandom_range(0, 700));
            ry = int'($urandom_range(0, 520));
            model_hit(rx, ry, idx);
            apply_stimulus(rx, ry);
            if (idx >= 0)
                check_output($sformatf("rand%0d_map%0d", n, idx), int'(map[idx]), ref_map[idx]);
            check_output($sformatf("rand%0d_walls", n), int'(walls_left), ref_walls);
        end
        nonzero = 0;
        for (int c = 0; c < 300; c++)
            if (int'(map[c]) != ref_map[c]) nonzero++;
        check_output("final_map_diffs", nonzero, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/tile_map_writer.md
# tile_map_writer

Owns the 20×15 playfield tile map that both tank instances read for collision. After reset, and on request, it fills the map from the level ROM. During play it applies shell-impact hits that damage or destroy brick tiles. It exports the full map combinationally from registers each frame, and reports the remaining destructible brick count to the game controller.

## Interface
Parameters:
- MAP_W, 20, tiles per row
- MAP_H, 15, tiles per column
- TILE_SHIFT, 5, log2 of tile size in pixels (32 px tiles)

Ports:
- frame_clk  in  1  frame clock; all state changes on its rising edge
- Reset  in  1  asynchronous, active-high
- level_load  in  1  pulse; restarts the LOAD sequence using level_sel
- level_sel  in  2  level number, sampled on the level_load cycle
- rom_addr  out  11  level ROM address = level*300 + cell
- rom_data  in  2  tile code; 1-cycle ROM read latency
- hit_valid  in  1  shell impact request
- hit_x, hit_y  in  10 each  impact pixel coordinate; held stable while hit_valid
- hit_ready  out  1  hit accepted when hit_valid && hit_ready
- map  out  int [300]  tile code per cell, index = row*20 + col
- load_done  out  1  high while in RUN
- walls_left  out  9  number of brick cells (codes 1 and 3)
- level_clear  out  1  one-cycle pulse when walls_left reaches 0 because of a hit

## Operation
Tile codes:
- 0: empty
- 1: brick
- 2: steel (indestructible)
- 3: damaged brick

FSM states are LOAD and RUN. Reset enters LOAD with level 0.

LOAD:
- The cell counter cnt runs from 0 to 299, driving rom_addr = level*300 + cnt.
- map[cnt-1] is written with rom_data one cycle later.
- walls_left is cleared on entry. It increments for each written code 1 or 3.
- hit_ready = 0 throughout.
- After the write of cell 299, the FSM moves to RUN.

RUN:
- hit_ready = 1, except on the cycle immediately after an accept (UPDATE sub-cycle).
- On accept, register row = hit_y >> 5 and col = hit_x >> 5.
- On the next edge:
  - row ≥ 15 or col ≥ 20: the hit is dropped, with no change.
  - code 0 or 2: no change.
  - code 1: becomes 3 (damage enabled) or 0 (damage disabled).
  - code 3: becomes 0.
- walls_left decrements on any transition to 0. If the new value is 0, level_clear pulses on the same edge.

Boundary rules:
- level_load in RUN, including during UPDATE: any pending hit is discarded. The FSM enters LOAD on the next edge.
- level_load during LOAD restarts at cnt = 0 with the new level_sel.
- Reset mid-load or mid-hit: immediate return to the reset state.
- walls_left never wraps. A decrement at 0 is impossible by construction and must be asserted against in simulation.

## Timing
Reset values:
- map all 0, walls_left 0
- load_done 0, hit_ready 0, level_clear 0
- rom_addr 0, state LOAD, cnt 0

Load sequence:
- The first edge after Reset deasserts issues address 0.
- The load occupies 301 edges.
- load_done and hit_ready rise after edge 301.

Hit path:
- The hit is accepted on edge k, and the map is updated on edge k+1.
- The new value is visible on map after k+1.
- hit_ready is low for the cycle following k, so sustained throughput is one hit per 2 cycles.

The map output is a direct register read, with no added latency to the tanks.

## Configuration
- TILE_MAP_DAMAGE_EN defined: bricks take two hits, 1→3→0.
- TILE_MAP_DAMAGE_EN undefined: bricks take one hit, 1→0. A ROM code 3 is stored as 1, and code 3 never appears on map.

## Structure
- Package tile_pkg: tile code constants (TILE_EMPTY, TILE_BRICK, TILE_STEEL, TILE_DAMAGED), MAP_W, MAP_H, MAP_CELLS=300, TILE_SHIFT, and the FSM state enum.
- Sub-module tile_index: combinational conversion of a pixel (x, y) to a cell index plus an in_range flag. The same block is reusable by the tank logic.

## Test plan
- Reset, then load with all-brick ROM level 0 → load_done rises after 301 edges, walls_left = 300, map[0] = map[299] = 1.
- Hit at (40, 70) on a brick cell, row 2 col 1 → map[41] = 3 after one edge and hit_ready low for one cycle; a second hit gives map[41] = 0 and walls_left decrements by 1. With the macro undefined, the first hit alone gives 0.
- Hits at (650, 10), on steel, and on an empty cell → map unchanged, walls_left unchanged.
- Level with a single brick, hit twice → walls_left = 0 and level_clear high for exactly one cycle.
- level_load asserted with level_sel = 2 on the cycle after a hit accept → the hit is discarded, rom_addr starts at 600, and hit_ready stays 0 until the reload completes.
- Reset asserted at cnt = 150 → all outputs return to their reset values immediately; the load restarts at address 0.
